// File: rtl/pc_op_enum.sv
// Shared IFU codes: PC write/increment selects consumed by pc, and the fetch FSM states.
package pc_op_enum;

    localparam logic [1:0] PC_WR_NEXT = 2'd0;
    localparam logic [1:0] PC_WR_JALR = 2'd1;
    localparam logic [1:0] PC_WR_ALU  = 2'd2;
    localparam logic [1:0] PC_WR_BOOT = 2'd3;

    localparam logic [1:0] PC_INC_4   = 2'd0;
    localparam logic [1:0] PC_INC_2   = 2'd1;
    localparam logic [1:0] PC_INC_4P  = 2'd2;
    localparam logic [1:0] PC_INC_2P  = 2'd3;

    typedef enum logic [2:0] {
        IFU_IDLE,
        IFU_REQ_LO,
        IFU_WAIT_LO,
        IFU_REQ_HI,
        IFU_WAIT_HI,
        IFU_ISSUE,
        IFU_DRAIN
    } ifu_state_t;

    // RVC instructions are any halfword whose low two bits are not 2'b11.
    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ifu_ctl.sv
// Fetch sequencer: word reads from imem, assembles RVC/32-bit (incl. straddling) instructions,
// hands them to decode via valid/ready and drives pc write-enable/select; one read outstanding.
module ifu_ctl
    import pc_op_enum::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] pc_data_i,
    output logic            pc_wr_en_o,
    output logic [1:0]      pc_wr_sel_o,
    output logic [1:0]      pc_inc_sel_o,
    input  logic            redirect_i,
    input  logic [1:0]      redirect_sel_i,
    output logic            imem_rd_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_data_o,
    output logic            inst_comp_o
);

    ifu_state_t      r_state;
    ifu_state_t      w_state_nxt;
    logic [31:0]     r_inst;
    logic            r_comp;
    logic [15:0]     r_lo;
    logic [XLEN-1:0] w_base;
    logic [15:0]     w_half;
    logic            w_unused_pc0;

    assign w_base       = {pc_data_i[XLEN-1:2], 2'b00};
    assign w_half       = pc_data_i[1] ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
    assign w_unused_pc0 = pc_data_i[0];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IFU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_inst <= 32'h0;
            r_comp <= 1'b0;
            r_lo   <= 16'h0;
        end else if (redirect_i) begin
            r_inst <= 32'h0;
            r_comp <= 1'b0;
        end else if (imem_rvalid_i && r_state == IFU_WAIT_LO) begin
            if (is_rvc(w_half)) begin
                r_inst <= {16'h0, w_half};
                r_comp <= 1'b1;
            end else if (!pc_data_i[1]) begin
                r_inst <= imem_rdata_i;
                r_comp <= 1'b0;
            end else begin
                r_lo <= w_half;
            end
        end else if (imem_rvalid_i && r_state == IFU_WAIT_HI) begin
            r_inst <= {imem_rdata_i[15:0], r_lo};
            r_comp <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        pc_wr_en_o   = 1'b0;
        pc_wr_sel_o  = PC_WR_NEXT;
        pc_inc_sel_o = PC_INC_4;
        imem_rd_o    = 1'b0;
        imem_addr_o  = '0;
        inst_valid_o = 1'b0;
        inst_data_o  = r_inst;
        inst_comp_o  = r_comp;

        case (r_state)
            IFU_IDLE:    w_state_nxt = IFU_REQ_LO;
            IFU_REQ_LO: begin
                imem_rd_o   = 1'b1;
                imem_addr_o = w_base;
                w_state_nxt = IFU_WAIT_LO;
            end
            IFU_WAIT_LO: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = (is_rvc(w_half) || !pc_data_i[1]) ? IFU_ISSUE : IFU_REQ_HI;
                end
            end
            IFU_REQ_HI: begin
                imem_rd_o   = 1'b1;
                imem_addr_o = w_base + XLEN'(4);
                w_state_nxt = IFU_WAIT_HI;
            end
            IFU_WAIT_HI: begin
                if (imem_rvalid_i) w_state_nxt = IFU_ISSUE;
            end
            IFU_ISSUE: begin
                inst_valid_o = !redirect_i;
                pc_inc_sel_o = r_comp ? PC_INC_2 : PC_INC_4;
                if (inst_valid_o && inst_ready_i) begin
                    pc_wr_en_o  = 1'b1;
                    w_state_nxt = IFU_REQ_LO;
                end
            end
            IFU_DRAIN: begin
                if (imem_rvalid_i) w_state_nxt = IFU_REQ_LO;
            end
            default:     w_state_nxt = IFU_IDLE;
        endcase

        // Redirect wins over an issue handshake; a read in flight must be drained first.
        if (redirect_i) begin
            pc_wr_en_o  = 1'b1;
            pc_wr_sel_o = redirect_sel_i;
            case (r_state)
                IFU_REQ_LO, IFU_REQ_HI:                w_state_nxt = IFU_DRAIN;
                IFU_WAIT_LO, IFU_WAIT_HI, IFU_DRAIN:   w_state_nxt = imem_rvalid_i ? IFU_REQ_LO : IFU_DRAIN;
                default:                               w_state_nxt = IFU_REQ_LO;
            endcase
        end

        if (!rst_n_i) begin
            pc_wr_en_o   = 1'b0;
            pc_wr_sel_o  = 2'b00;
            pc_inc_sel_o = 2'b00;
            imem_rd_o    = 1'b0;
            imem_addr_o  = '0;
            inst_valid_o = 1'b0;
            inst_data_o  = 32'h0;
            inst_comp_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifu_ctl.sv
// Directed bench for ifu_ctl with a behavioural pc register and a variable-latency imem responder.
module tb_ifu_ctl;
    import pc_op_enum::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_q;
    logic        pc_wr_en_o;
    logic [1:0]  pc_wr_sel_o, pc_inc_sel_o;
    logic        redirect_i;
    logic [1:0]  redirect_sel_i;
    logic        imem_rd_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid_o, inst_ready, inst_comp_o;
    logic [31:0] inst_data_o;

    logic        pc_load;
    logic [31:0] pc_load_val, alu_tgt;
    int          nxt_cnt;
    logic [31:0] a0, a1, w0, w1;
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] p_addr;
    int          rv_cnt;
    logic [31:0] rd_log[$];
    int          rv_log[$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ifu_ctl #(.XLEN(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pc_data_i(pc_q),
        .pc_wr_en_o(pc_wr_en_o), .pc_wr_sel_o(pc_wr_sel_o), .pc_inc_sel_o(pc_inc_sel_o),
        .redirect_i(redirect_i), .redirect_sel_i(redirect_sel_i),
        .imem_rd_o(imem_rd_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready),
        .inst_data_o(inst_data_o), .inst_comp_o(inst_comp_o)
    );

    always @(posedge clk) begin
        if (pc_load) begin
            pc_q    <= pc_load_val;
            nxt_cnt <= 0;
        end else if (pc_wr_en_o) begin
            if (pc_wr_sel_o == PC_WR_NEXT) begin
                pc_q    <= pc_q + ((pc_inc_sel_o == PC_INC_2) ? 32'd2 : 32'd4);
                nxt_cnt <= nxt_cnt + 1;
            end else begin
                pc_q <= alu_tgt;
            end
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == a0) ? w0 : (a == a1) ? w1 : 32'hDEADBEEF;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            pend        <= 1'b0;
            cnt         <= 0;
            p_addr      <= 32'h0;
            rv_cnt      <= 0;
            rd_log.delete();
            rv_log.delete();
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_rd_o) begin
                rd_log.push_back(imem_addr_o);
                rv_log.push_back(rv_cnt);
                p_addr <= imem_addr_o;
                if (lat == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_rd(imem_addr_o);
                    rv_cnt      <= rv_cnt + 1;
                end else begin
                    pend <= 1'b1;
                    cnt  <= lat;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_rd(p_addr);
                    pend        <= 1'b0;
                    rv_cnt      <= rv_cnt + 1;
                end
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (inst_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_valid_seen"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_rd(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_rd_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_rd_seen"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic start(input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                         input int l, input logic rdy);
        @(negedge clk);
        rst_n       = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = pc;
        a0          = {pc[31:2], 2'b00};
        a1          = a0 + 32'd4;
        w0          = d0;
        w1          = d1;
        lat         = l;
        inst_ready  = rdy;
        redirect_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pc_load = 1'b0;
        rst_n   = 1'b1;
    endtask

    typedef struct {
        logic [31:0] pc, w0, w1, inst;
        logic        comp;
        logic [31:0] npc, ad0, ad1;
        int          nrd;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [31:0] sz;
        rst_n = 1'b0; pc_load = 1'b1; pc_load_val = 32'h1234; alu_tgt = 32'h0;
        redirect_i = 1'b1; redirect_sel_i = PC_WR_ALU; inst_ready = 1'b1;
        a0 = 0; a1 = 4; w0 = 0; w1 = 0; lat = 0;

        vt[0] = '{32'h0,        32'h00500093, 32'h0,        32'h00500093, 1'b0, 32'h4,        32'h0,        32'h4,        1};
        vt[1] = '{32'h100,      32'h45814501, 32'h0,        32'h00004501, 1'b1, 32'h102,      32'h100,      32'h104,      1};
        vt[2] = '{32'h102,      32'h45814501, 32'h0,        32'h00004581, 1'b1, 32'h104,      32'h100,      32'h104,      1};
        vt[3] = '{32'h202,      32'h00930000, 32'hABCD0050, 32'h00500093, 1'b0, 32'h206,      32'h200,      32'h204,      2};
        vt[4] = '{32'hFFFFFFFE, 32'h00130000, 32'h12340000, 32'h00000013, 1'b0, 32'h2,        32'hFFFFFFFC, 32'h0,        2};
        vt[5] = '{32'h302,      32'h80821111, 32'h0,        32'h00008082, 1'b1, 32'h304,      32'h300,      32'h304,      1};
        vt[6] = '{32'h104,      32'hFFF00513, 32'h0,        32'hFFF00513, 1'b0, 32'h108,      32'h104,      32'h108,      1};

        // Reset: every output low even with redirect asserted.
        @(negedge clk); @(negedge clk);
        chk("rst_pc_wr_en", {31'h0, pc_wr_en_o}, 32'h0);
        chk("rst_imem_rd", {31'h0, imem_rd_o}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_inst_comp", {31'h0, inst_comp_o}, 32'h0);
        chk("rst_imem_addr", imem_addr_o, 32'h0);
        chk("rst_inst_data", inst_data_o, 32'h0);
        chk("rst_wr_sel", {30'h0, pc_wr_sel_o}, 32'h0);
        chk("rst_inc_sel", {30'h0, pc_inc_sel_o}, 32'h0);
        redirect_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start(vt[i].pc, vt[i].w0, vt[i].w1, 0, 1'b1);
            wait_valid($sformatf("v%0d", i));
            chk($sformatf("v%0d_data", i), inst_data_o, vt[i].inst);
            chk($sformatf("v%0d_comp", i), {31'h0, inst_comp_o}, {31'h0, vt[i].comp});
            chk($sformatf("v%0d_wr_en", i), {31'h0, pc_wr_en_o}, 32'h1);
            chk($sformatf("v%0d_wr_sel", i), {30'h0, pc_wr_sel_o}, {30'h0, PC_WR_NEXT});
            chk($sformatf("v%0d_inc", i), {30'h0, pc_inc_sel_o}, {30'h0, vt[i].comp ? PC_INC_2 : PC_INC_4});
            sz = rd_log.size();
            chk($sformatf("v%0d_nrd", i), sz, vt[i].nrd);
            chk($sformatf("v%0d_addr0", i), (sz > 0) ? rd_log[0] : 32'hFFFFFFFF, vt[i].ad0);
            if (vt[i].nrd > 1)
                chk($sformatf("v%0d_addr1", i), (sz > 1) ? rd_log[1] : 32'hFFFFFFFF, vt[i].ad1);
            @(negedge clk);
            chk($sformatf("v%0d_next_pc", i), pc_q, vt[i].npc);
        end

        // Back-pressure: ten stalled cycles in ISSUE.
        start(32'h100, 32'h45814501, 32'h0, 0, 1'b0);
        wait_valid("bp");
        sz = rd_log.size();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'h0, inst_valid_o}, 32'h1);
            chk("bp_data", inst_data_o, 32'h00004501);
            chk("bp_wr_en", {31'h0, pc_wr_en_o}, 32'h0);
            chk("bp_rd", {31'h0, imem_rd_o}, 32'h0);
            @(negedge clk);
        end
        chk("bp_nrd", rd_log.size(), sz);
        inst_ready = 1'b1;
        #1;
        chk("bp_accept_wr_en", {31'h0, pc_wr_en_o}, 32'h1);
        chk("bp_accept_inc", {30'h0, pc_inc_sel_o}, {30'h0, PC_INC_2});
        @(negedge clk);
        chk("bp_next_pc", pc_q, 32'h102);

        // Redirect in WAIT_LO with slow memory: drain, then fetch at target.
        start(32'h0, 32'h00500093, 32'h0, 4, 1'b1);
        a1 = 32'h400; w1 = 32'h00000513;
        wait_rd("wl");
        @(negedge clk);
        redirect_i = 1'b1; redirect_sel_i = PC_WR_ALU; alu_tgt = 32'h400;
        #1;
        chk("wl_wr_en", {31'h0, pc_wr_en_o}, 32'h1);
        chk("wl_wr_sel", {30'h0, pc_wr_sel_o}, {30'h0, PC_WR_ALU});
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        chk("wl_drain_no_rd", {31'h0, imem_rd_o}, 32'h0);
        chk("wl_pc", pc_q, 32'h400);
        wait_valid("wl");
        chk("wl_data", inst_data_o, 32'h00000513);
        sz = rd_log.size();
        chk("wl_nrd", sz, 32'd2);
        chk("wl_addr1", (sz > 1) ? rd_log[1] : 32'hFFFFFFFF, 32'h400);
        chk("wl_rd_after_rvalid", (sz > 1) ? rv_log[1] : -1, 32'd1);

        // Redirect in WAIT_LO coinciding with rvalid: no drain.
        start(32'h0, 32'h00500093, 32'h0, 0, 1'b1);
        a1 = 32'h500; w1 = 32'h00100073;
        wait_rd("rv");
        @(negedge clk);
        redirect_i = 1'b1; redirect_sel_i = PC_WR_ALU; alu_tgt = 32'h500;
        #1;
        chk("rv_rvalid_present", {31'h0, imem_rvalid}, 32'h1);
        chk("rv_wr_en", {31'h0, pc_wr_en_o}, 32'h1);
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        chk("rv_rd", {31'h0, imem_rd_o}, 32'h1);
        chk("rv_addr", imem_addr_o, 32'h500);
        wait_valid("rv");
        chk("rv_data", inst_data_o, 32'h00100073);

        // Redirect coincident with valid && ready.
        start(32'h0, 32'h00500093, 32'h0, 0, 1'b0);
        a1 = 32'h800; w1 = 32'h00000013;
        wait_valid("co");
        inst_ready = 1'b1; redirect_i = 1'b1; redirect_sel_i = PC_WR_JALR; alu_tgt = 32'h800;
        #1;
        chk("co_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("co_wr_en", {31'h0, pc_wr_en_o}, 32'h1);
        chk("co_wr_sel", {30'h0, pc_wr_sel_o}, {30'h0, PC_WR_JALR});
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        chk("co_pc", pc_q, 32'h800);
        chk("co_no_next", nxt_cnt, 32'd0);
        chk("co_rd", {31'h0, imem_rd_o}, 32'h1);
        chk("co_addr", imem_addr_o, 32'h800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
